// File: rtl/sd_uart_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// sd_uart_xfer_ctrl
//   Sequencer for the SD-card-to-UART dump path. Requests one SD block at a
//   time, but only when the FIFO can accept a whole block. Keeps the
//   FIFO-to-UART drain enabled for the whole job, counts transmitted bytes and
//   reports done / error / progress.
//
// Ports
//   clk, reset     system clock, asynchronous active-high reset
//   start, abort   one-cycle control pulses from the push-button logic
//   num_blocks     blocks to transfer, sampled when a start is accepted
//   sd_init_done   SD card initialised (level)
//   sd_finish      SD reader finished the current block (level)
//   sd_start       SD read request (level)
//   fifo_count     FIFO occupancy in bytes
//   fifo_empty     FIFO empty flag
//   byte_sent      one pulse per byte completed on the UART tx
//   drain_en       enable for the FIFO-to-UART stage
//   busy           job in progress
//   done           one-cycle pulse on successful completion
//   err_code       0 none, 1 read timeout, 2 init timeout, 3 aborted (sticky)
//   blocks_done    blocks completed in the current job
//   bytes_sent     bytes transmitted in the current job (saturating)
//   state_dbg      encoded state for the seven-segment debug display
// -----------------------------------------------------------------------------
module sd_uart_xfer_ctrl #(
   parameter int BLOCK_BYTES  = 512,
   parameter int FIFO_DEPTH   = 1024,
   parameter int INIT_TIMEOUT = 2000000,
   parameter int READ_TIMEOUT = 200000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  num_blocks,
   input  logic        sd_init_done,
   input  logic        sd_finish,
   output logic        sd_start,
   input  logic [9:0]  fifo_count,
   input  logic        fifo_empty,
   input  logic        byte_sent,
   output logic        drain_en,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err_code,
   output logic [7:0]  blocks_done,
   output logic [16:0] bytes_sent,
   output logic [3:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_WAIT_INIT   = 3'd1,
      S_CHECK_SPACE = 3'd2,
      S_READ_REQ    = 3'd3,
      S_READ_WAIT   = 3'd4,
      S_GAP         = 3'd5,
      S_DRAIN       = 3'd6,
      S_FINISH      = 3'd7
   } state_t;

   localparam logic [1:0]  ERR_NONE  = 2'd0;
   localparam logic [1:0]  ERR_READ  = 2'd1;
   localparam logic [1:0]  ERR_INIT  = 2'd2;
   localparam logic [1:0]  ERR_ABORT = 2'd3;

   // Largest occupancy that still leaves room for one complete block.
   localparam logic [31:0] SPACE_LIMIT = 32'(FIFO_DEPTH - BLOCK_BYTES);
   // Timer values at which the last allowed cycle has elapsed.
   localparam logic [31:0] INIT_LAST   = 32'(INIT_TIMEOUT - 1);
   localparam logic [31:0] READ_LAST   = 32'(READ_TIMEOUT - 1);
   localparam logic [16:0] BLOCK_W     = 17'(BLOCK_BYTES);

   state_t      state_q, state_d;
   logic        sd_start_q, sd_start_d;
   logic        drain_en_q, drain_en_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  err_q, err_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  blocks_q, blocks_d;
   logic [16:0] bytes_q, bytes_d;
   logic [31:0] timer_q, timer_d;
   logic [16:0] target_bytes;

   // 255 * 512 = 130560 still fits in 17 bits.
   assign target_bytes = 17'(count_q) * BLOCK_W;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sd_start_q <= 1'b0;
         drain_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= ERR_NONE;
         count_q    <= '0;
         blocks_q   <= '0;
         bytes_q    <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         sd_start_q <= sd_start_d;
         drain_en_q <= drain_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         count_q    <= count_d;
         blocks_q   <= blocks_d;
         bytes_q    <= bytes_d;
         timer_q    <= timer_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sd_start_d = sd_start_q;
      drain_en_d = drain_en_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      count_d    = count_q;
      blocks_d   = blocks_q;
      bytes_d    = bytes_q;
      timer_d    = timer_q;

      // The drain runs alongside the reads, so bytes are counted in any busy state.
      if (busy_q && byte_sent && (bytes_q != '1)) begin
         bytes_d = bytes_q + 17'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               count_d  = num_blocks;
               blocks_d = '0;
               bytes_d  = '0;
               err_d    = ERR_NONE;
               timer_d  = '0;
               busy_d   = 1'b1;
               state_d  = (num_blocks == 8'd0) ? S_FINISH : S_WAIT_INIT;
            end
         end
         S_WAIT_INIT: begin
            if (sd_init_done) begin
               drain_en_d = 1'b1;
               state_d    = S_CHECK_SPACE;
            end else if (timer_q >= INIT_LAST) begin
               err_d      = ERR_INIT;
               busy_d     = 1'b0;
               drain_en_d = 1'b0;
               sd_start_d = 1'b0;
               state_d    = S_IDLE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_CHECK_SPACE: begin
            if (blocks_q == count_q) begin
               state_d = S_DRAIN;
            end else if (32'(fifo_count) <= SPACE_LIMIT) begin
               state_d = S_READ_REQ;
            end
         end
         S_READ_REQ: begin
            sd_start_d = 1'b1;
            timer_d    = '0;
            state_d    = S_READ_WAIT;
         end
         S_READ_WAIT: begin
            if (sd_finish) begin
               blocks_d   = blocks_q + 8'd1;
               sd_start_d = 1'b0;
               state_d    = S_GAP;
            end else if (timer_q >= READ_LAST) begin
               sd_start_d = 1'b0;
               err_d      = ERR_READ;
               busy_d     = 1'b0;
               drain_en_d = 1'b0;
               state_d    = S_IDLE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_GAP: begin
            // One guaranteed low cycle on sd_start between consecutive blocks.
            state_d = S_CHECK_SPACE;
         end
         S_DRAIN: begin
            if (fifo_empty && (bytes_q == target_bytes)) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            done_d     = 1'b1;
            drain_en_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides whatever the state logic decided this cycle, including
      // a block completion or a timeout arriving at the same time.
      if (abort && (state_q != S_IDLE)) begin
         sd_start_d = 1'b0;
         drain_en_d = 1'b0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         err_d      = ERR_ABORT;
         blocks_d   = blocks_q;
         state_d    = S_IDLE;
      end
   end

   assign sd_start    = sd_start_q;
   assign drain_en    = drain_en_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_code    = err_q;
   assign blocks_done = blocks_q;
   assign bytes_sent  = bytes_q;
   assign state_dbg   = 4'(state_q);

endmodule

// File: doc/sd_uart_xfer_ctrl.md
Name: sd_uart_xfer_ctrl

Overview:
- Sequencer for the SD-card-to-UART dump path.
- Issues per-block read requests to the SD reader only when the FIFO has room for a whole block.
- Keeps the FIFO-to-UART drain enabled for the whole job and counts transmitted bytes.
- Reports done, error and progress; sits between the push-button/start logic and the SD reader, FIFO and FIFO-to-UART chain.

Parameters:
BLOCK_BYTES, 512, bytes written into the FIFO per SD block read
FIFO_DEPTH, 1024, FIFO capacity in bytes
INIT_TIMEOUT, 2000000, clk cycles allowed for sd_init_done after start
READ_TIMEOUT, 200000, clk cycles allowed from sd_start rise to sd_finish

Ports:
clk  in  1  system clock (UART-rate divided clock); all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle start pulse
abort  in  1  one-cycle abort pulse
num_blocks  in  8  blocks to transfer; sampled on accepted start
sd_init_done  in  1  SD card initialised (level)
sd_finish  in  1  SD reader finished current block (level, held until sd_start drops)
sd_start  out  1  SD read request (level)
fifo_count  in  10  current FIFO occupancy
fifo_empty  in  1  FIFO empty flag
byte_sent  in  1  one-cycle pulse per byte completed on tx
drain_en  out  1  enable to FIFO-to-UART stage
busy  out  1  job in progress
done  out  1  one-cycle pulse on successful completion
err_code  out  2  0 none, 1 read timeout, 2 init timeout, 3 aborted; sticky until next accepted start
blocks_done  out  8  blocks completed in current job
bytes_sent  out  17  bytes transmitted in current job
state_dbg  out  4  encoded state for the seven-segment debug display

Behaviour:
- Reset (async): state IDLE; sd_start, drain_en, busy and done are 0; err_code, blocks_done, bytes_sent and timers are 0.
- State encodings: IDLE=0, WAIT_INIT=1, CHECK_SPACE=2, READ_REQ=3, READ_WAIT=4, GAP=5, DRAIN=6, FINISH=7.
- IDLE: start=1 latches num_blocks, clears counters and err_code, sets busy=1, then goes to WAIT_INIT. If the latched num_blocks=0, go to FINISH instead.
- start while busy: ignored.
- WAIT_INIT: on sd_init_done=1, go to CHECK_SPACE and set drain_en=1. If the timer reaches INIT_TIMEOUT, set err_code=2 and go to IDLE.
- CHECK_SPACE:
  - If blocks_done==latched count, go to DRAIN.
  - Else if fifo_count <= FIFO_DEPTH-BLOCK_BYTES, go to READ_REQ.
  - Else stay.
- READ_REQ: sd_start<=1 and clear the read timer; next cycle go to READ_WAIT.
- READ_WAIT: sd_start held at 1.
  - On sd_finish=1: blocks_done+1, sd_start<=0, go to GAP.
  - If the timer reaches READ_TIMEOUT: sd_start<=0, err_code=1, go to IDLE.
- GAP: sd_start held at 0 for exactly one cycle, then go to CHECK_SPACE. This guarantees a low pulse on sd_start between blocks.
- DRAIN: when fifo_empty=1 and bytes_sent==count*BLOCK_BYTES, go to FINISH.
- FINISH: done=1 for one cycle, drain_en<=0, busy<=0, go to IDLE.
- bytes_sent:
  - Increments on every byte_sent pulse while busy=1, including in READ states; drain runs concurrently with reads.
  - Saturates at 2^17-1.
  - Product count*BLOCK_BYTES is computed at 17 bits; 255*512=130560 fits.
- abort=1 in any non-IDLE state: sd_start<=0, drain_en<=0, busy<=0, err_code=3, go to IDLE next cycle. Abort takes priority over sd_finish and timeouts in the same cycle.
- On any return to IDLE, blocks_done and bytes_sent hold their last values until the next accepted start.
- Reset mid-operation: immediate return to reset values; no pending request is retained.
- sd_finish outside READ_WAIT: ignored.

Test Plan:
- start with num_blocks=2, sd_init_done=1, FIFO model drains 1 byte per 10 cycles -> two sd_start pulses, each with a low gap >=1 cycle; blocks_done=2, bytes_sent=1024, single done pulse, err_code=0.
- fifo_count=600 at CHECK_SPACE -> sd_start stays 0 until fifo_count falls to 512, then asserts within 2 cycles.
- num_blocks=0 -> done pulse within 2 cycles of start; sd_start never asserted.
- sd_finish withheld for READ_TIMEOUT cycles -> sd_start drops, err_code=1, busy=0, no done pulse.
- abort in the same cycle as sd_finish during block 1 -> err_code=3, blocks_done=0, sd_start=0 and drain_en=0 next cycle.
- reset asserted mid-READ_WAIT, start re-pulsed during busy -> outputs reset asynchronously; the start pulse issued while busy has no effect.
